// File: rtl/writeback_stage.sv
// MEM/WB pipeline latch and writeback datapath: source select, sub-word load
// extraction, retired-instruction counting and the sticky halt flag.
module writeback_stage #(
    parameter int WORD_W = 32,
    parameter int RSEL_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_regwen,
    input  logic [RSEL_W-1:0] mem_wsel,
    input  logic [1:0]        mem_wbsel,
    input  logic [2:0]        mem_ldtype,
    input  logic [WORD_W-1:0] mem_alu_out,
    input  logic [WORD_W-1:0] mem_dload,
    input  logic [WORD_W-1:0] mem_npc,
    input  logic              mem_halt,
    output logic              WEN,
    output logic [RSEL_W-1:0] wsel,
    output logic [WORD_W-1:0] wdat,
    output logic              halt,
    output logic [31:0]       retire_cnt
);

    logic              valid_q;
    logic              regwen_q;
    logic [RSEL_W-1:0] wsel_q;
    logic [1:0]        wbsel_q;
    logic [2:0]        ldtype_q;
    logic [WORD_W-1:0] alu_q;
    logic [WORD_W-1:0] dload_q;
    logic [WORD_W-1:0] npc_q;
    logic              halt_q;

    logic              capture;
    logic [1:0]        off;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [WORD_W-1:0] load_val;

    assign capture = ~halt & ~flush & ~stall;

    // Sticky halt is decided by the register value at the edge, so the
    // instruction presented on the edge that sets halt is still captured.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q  <= 1'b0;
            regwen_q <= 1'b0;
            wsel_q   <= '0;
            wbsel_q  <= 2'b00;
            ldtype_q <= 3'b000;
            alu_q    <= '0;
            dload_q  <= '0;
            npc_q    <= '0;
            halt_q   <= 1'b0;
        end else if (!halt) begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q  <= mem_valid;
                regwen_q <= mem_regwen;
                wsel_q   <= mem_wsel;
                wbsel_q  <= mem_wbsel;
                ldtype_q <= mem_ldtype;
                alu_q    <= mem_alu_out;
                dload_q  <= mem_dload;
                npc_q    <= mem_npc;
                halt_q   <= mem_halt;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halt       <= 1'b0;
            retire_cnt <= 32'd0;
        end else begin
            halt <= halt | (valid_q & halt_q);
            if (capture && mem_valid) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    // Little-endian extraction; halfword uses only off[1], no misalign trap.
    always_comb begin
        off      = alu_q[1:0];
        byte_val = 8'(dload_q >> {off, 3'b000});
        half_val = off[1] ? dload_q[31:16] : dload_q[15:0];
        load_val = dload_q;
        case (ldtype_q)
            3'b001:  load_val = {{24{byte_val[7]}}, byte_val};
            3'b010:  load_val = {{16{half_val[15]}}, half_val};
            3'b011:  load_val = {24'd0, byte_val};
            3'b100:  load_val = {16'd0, half_val};
            default: load_val = dload_q;
        endcase
    end

    always_comb begin
        wdat = alu_q;
        case (wbsel_q)
            2'b01:   wdat = load_val;
            2'b10:   wdat = npc_q;
            default: wdat = alu_q;
        endcase
    end

    assign wsel = wsel_q;
    assign WEN  = valid_q & regwen_q & ~halt_q & ~halt & (wsel_q != '0);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: reset, writeback sources,
// load extraction, r0 suppression, stall/flush and sticky halt.
module tb_writeback_stage;

    logic        CLK;
    logic        RST;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_regwen;
    logic [4:0]  mem_wsel;
    logic [1:0]  mem_wbsel;
    logic [2:0]  mem_ldtype;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_dload;
    logic [31:0] mem_npc;
    logic        mem_halt;
    logic        WEN;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        halt;
    logic [31:0] retire_cnt;

    int checks;
    int failures;

    writeback_stage #(.WORD_W(32), .RSEL_W(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .stall      (stall),
        .flush      (flush),
        .mem_valid  (mem_valid),
        .mem_regwen (mem_regwen),
        .mem_wsel   (mem_wsel),
        .mem_wbsel  (mem_wbsel),
        .mem_ldtype (mem_ldtype),
        .mem_alu_out(mem_alu_out),
        .mem_dload  (mem_dload),
        .mem_npc    (mem_npc),
        .mem_halt   (mem_halt),
        .WEN        (WEN),
        .wsel       (wsel),
        .wdat       (wdat),
        .halt       (halt),
        .retire_cnt (retire_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic applyStimulus(input logic v, input logic rw, input logic [4:0] ws,
                                 input logic [1:0] wb, input logic [2:0] lt,
                                 input logic [31:0] alu, input logic [31:0] dl,
                                 input logic [31:0] npc, input logic hl);
        mem_valid   = v;
        mem_regwen  = rw;
        mem_wsel    = ws;
        mem_wbsel   = wb;
        mem_ldtype  = lt;
        mem_alu_out = alu;
        mem_dload   = dl;
        mem_npc     = npc;
        mem_halt    = hl;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input logic en, input logic [4:0] sel,
                              input logic [31:0] dat, input logic [31:0] cnt);
        checkOutput({tag, ".WEN"}, {31'd0, WEN}, {31'd0, en});
        checkOutput({tag, ".wsel"}, {27'd0, wsel}, {27'd0, sel});
        checkOutput({tag, ".wdat"}, wdat, dat);
        checkOutput({tag, ".retire"}, retire_cnt, cnt);
    endtask

    localparam logic [31:0] DL = 32'h80FF_7F01;

    initial begin
        checks   = 0;
        failures = 0;
        RST      = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        applyStimulus(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0);
        #12;
        checkWrite("reset", 0, 0, 32'h0, 0);
        checkOutput("reset.halt", {31'd0, halt}, 32'd0);
        RST = 1'b0;

        applyStimulus(1, 1, 5, 2'b00, 3'b000, 32'h1234_5678, 0, 0, 0);
        tick();
        checkWrite("alu", 1, 5, 32'h1234_5678, 1);

        applyStimulus(1, 1, 6, 2'b01, 3'b001, 32'h0000_1003, DL, 0, 0);
        tick();
        checkWrite("lb_off3", 1, 6, 32'hFFFF_FF80, 2);

        applyStimulus(1, 1, 6, 2'b01, 3'b011, 32'h0000_1001, DL, 0, 0);
        tick();
        checkWrite("lbu_off1", 1, 6, 32'h0000_007F, 3);

        applyStimulus(1, 1, 6, 2'b01, 3'b010, 32'h0000_1002, DL, 0, 0);
        tick();
        checkWrite("lh_off2", 1, 6, 32'hFFFF_80FF, 4);

        applyStimulus(1, 1, 6, 2'b01, 3'b100, 32'h0000_1000, DL, 0, 0);
        tick();
        checkWrite("lhu_off0", 1, 6, 32'h0000_7F01, 5);

        applyStimulus(1, 1, 6, 2'b01, 3'b000, 32'h0000_1000, DL, 0, 0);
        tick();
        checkWrite("lw", 1, 6, DL, 6);

        applyStimulus(1, 1, 6, 2'b01, 3'b111, 32'h0000_1001, DL, 0, 0);
        tick();
        checkWrite("ld_other", 1, 6, DL, 7);

        applyStimulus(1, 1, 1, 2'b10, 3'b000, 32'h0000_0055, DL, 32'h104, 0);
        tick();
        checkWrite("jal", 1, 1, 32'h0000_0104, 8);

        applyStimulus(1, 1, 8, 2'b11, 3'b000, 32'h0000_ABCD, DL, 32'h104, 0);
        tick();
        checkWrite("wbsel11", 1, 8, 32'h0000_ABCD, 9);

        applyStimulus(1, 1, 0, 2'b00, 3'b000, 32'h0000_DEAD, 0, 0, 0);
        tick();
        checkWrite("r0", 0, 0, 32'h0000_DEAD, 10);

        applyStimulus(1, 0, 7, 2'b00, 3'b000, 32'h0000_0011, 0, 0, 0);
        tick();
        checkWrite("noregwen", 0, 7, 32'h0000_0011, 11);

        applyStimulus(0, 1, 7, 2'b00, 3'b000, 32'h0000_0022, 0, 0, 0);
        tick();
        checkWrite("invalid", 0, 7, 32'h0000_0022, 11);

        // Capture once, then hold through a 3-cycle stall with new inputs waiting.
        applyStimulus(1, 1, 9, 2'b00, 3'b000, 32'h0000_0077, 0, 0, 0);
        tick();
        checkWrite("stall_c0", 1, 9, 32'h0000_0077, 12);
        applyStimulus(1, 1, 10, 2'b00, 3'b000, 32'h0000_0099, 0, 0, 0);
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkWrite($sformatf("stall_c%0d", i), 1, 9, 32'h0000_0077, 12);
        end
        stall = 1'b0;
        tick();
        checkWrite("stall_release", 1, 10, 32'h0000_0099, 13);

        flush = 1'b1;
        stall = 1'b1;
        applyStimulus(1, 1, 11, 2'b00, 3'b000, 32'h0000_00AA, 0, 0, 0);
        tick();
        checkOutput("flushstall.WEN", {31'd0, WEN}, 32'd0);
        checkOutput("flushstall.retire", retire_cnt, 32'd13);
        stall = 1'b0;
        tick();
        checkOutput("flush.WEN", {31'd0, WEN}, 32'd0);
        checkOutput("flush.retire", retire_cnt, 32'd13);
        flush = 1'b0;

        // HALT in WB, followed by valid writes that must never be committed.
        applyStimulus(1, 1, 3, 2'b00, 3'b000, 32'h0000_0033, 0, 0, 1);
        tick();
        checkOutput("halt_wb.WEN", {31'd0, WEN}, 32'd0);
        checkOutput("halt_wb.halt", {31'd0, halt}, 32'd0);
        checkOutput("halt_wb.retire", retire_cnt, 32'd14);
        applyStimulus(1, 1, 4, 2'b00, 3'b000, 32'h0000_0044, 0, 0, 0);
        tick();
        checkOutput("halt_set.halt", {31'd0, halt}, 32'd1);
        checkWrite("halt_set", 0, 4, 32'h0000_0044, 15);
        applyStimulus(1, 1, 12, 2'b00, 3'b000, 32'h0000_00CC, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("halted%0d.halt", i), {31'd0, halt}, 32'd1);
            checkWrite($sformatf("halted%0d", i), 0, 4, 32'h0000_0044, 15);
        end

        #2;
        RST = 1'b1;
        #1;
        checkOutput("rst_halt.halt", {31'd0, halt}, 32'd0);
        checkWrite("rst_halt", 0, 0, 32'h0, 0);
        RST = 1'b0;

        applyStimulus(1, 1, 2, 2'b00, 3'b000, 32'h0000_CAFE, 0, 0, 0);
        tick();
        checkWrite("post_rst", 1, 2, 32'h0000_CAFE, 1);
        #2;
        RST = 1'b1;
        #1;
        checkWrite("rst_async", 0, 0, 32'h0, 0);
        checkOutput("rst_async.halt", {31'd0, halt}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline latch plus writeback datapath. It drives the write port (WEN, wsel, wdat) of the register file.
- Captures MEM-stage results, then selects the writeback source: ALU result, load data or next PC.
- Performs sub-word load extraction with sign/zero extension.
- Tracks retired instructions and the sticky halt condition for the datapath top level.

Parameters:
- WORD_W, 32, datapath width; only 32 is supported.
- RSEL_W, 5, register select width.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- stall  input  1  hold latch contents.
- flush  input  1  squash latch contents (insert bubble).
- mem_valid  input  1  MEM stage holds a real instruction.
- mem_regwen  input  1  instruction writes rd.
- mem_wsel  input  RSEL_W  destination register.
- mem_wbsel  input  2  source: 00 ALU, 01 load, 10 next PC, 11 ALU.
- mem_ldtype  input  3  000 LW, 001 LB, 010 LH, 011 LBU, 100 LHU, others LW.
- mem_alu_out  input  WORD_W  ALU result / load address.
- mem_dload  input  WORD_W  raw word read from data memory.
- mem_npc  input  WORD_W  PC+4.
- mem_halt  input  1  instruction is HALT.
- WEN  output  1  register file write enable.
- wsel  output  RSEL_W  register file write select.
- wdat  output  WORD_W  register file write data.
- halt  output  1  sticky halt.
- retire_cnt  output  32  count of retired instructions.

Behaviour:
- Reset (RST=1, asynchronous):
  - All latch fields cleared, including valid=0.
  - halt=0, retire_cnt=0.
  - WEN=0, wsel=0, wdat=0.
  - Reset asserted mid-operation discards the in-flight instruction immediately, without waiting for a clock edge.
- Latch update on each rising CLK, in priority order:
  1. halt=1: latch frozen, inputs ignored.
  2. flush=1: valid cleared; other fields don't-care. Flush beats stall.
  3. stall=1: hold all fields.
  4. Otherwise: capture all mem_* fields.
- Latency: exactly one cycle from mem_* inputs to WEN/wsel/wdat. Outputs are combinational from the latch only, with no direct input-to-output path.
- WEN = valid & regwen & ~halt_latched & (wsel != 0).
  - HALT instructions never write.
  - wsel=0 never asserts WEN, so r0 stays zero.
- While stalled, WEN/wsel/wdat remain asserted with identical values. The repeated write is idempotent and allowed.
- wsel = latched wsel.
- wdat source selection: wbsel 00/11 -> alu_out; 01 -> extracted load; 10 -> npc.
- Load extraction, little-endian, off = latched alu_out[1:0]:
  - LW: dload.
  - LB/LBU: byte dload[8*off+7 : 8*off], sign- or zero-extended to 32 bits.
  - LH/LHU: halfword at dload[16*off[1]+15 : 16*off[1]]; off[0] is ignored (no misalign trap). Sign- or zero-extended.
- retire_cnt:
  - +1 on each edge where a valid instruction is captured (no flush, no stall, halt=0, mem_valid=1).
  - Wraps at 2^32 silently.
  - A HALT instruction counts.
- halt:
  - Set on the edge after the latch holds valid & halt, i.e. the cycle after HALT reaches WB.
  - Remains 1 until RST.
  - Once halt=1, WEN is forced 0.
- flush and stall asserted together: result is a bubble; retire_cnt unchanged.

Test Plan:
- Reset: assert RST mid-run with a valid write in the latch -> WEN=0, wdat=0, retire_cnt=0, halt=0 immediately, without waiting for a clock edge.
- ALU writeback: wsel=5, wbsel=00, alu_out=0x1234_5678, regwen=1 -> next cycle WEN=1, wsel=5, wdat=0x12345678, retire_cnt=1.
- Loads, dload=0x80FF_7F01:
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=1 -> 0x0000007F.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - JAL (wbsel=10, npc=0x104) -> 0x104.
- Write to r0: regwen=1, wsel=0, alu_out=0xDEAD -> WEN=0; retire_cnt still increments.
- Stall/flush:
  - 3-cycle stall -> WEN/wdat constant for 4 cycles; retire_cnt increments once.
  - flush+stall in the same cycle -> WEN=0 next cycle; retire_cnt unchanged.
- Halt: valid HALT, then valid writes following -> halt=1 one cycle after HALT in WB; WEN stays 0; retire_cnt frozen; state persists until RST.
